kernel_serializer: RTL and testbench
====================================

KERNEL_SERIALIZER -- requirements
Module: kernel_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of one pixel element.
REQ-002 The block SHALL have parameter BLOCK_WIDTH, default 3, giving the number of elements per parallel word (minimum 2).
REQ-003 The block SHALL have derived parameter INPUT_WIDTH, default DATA_WIDTH*BLOCK_WIDTH, giving the parallel word width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  INPUT_WIDTH  parallel word; element k = in_data[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 out_data  output  DATA_WIDTH  current serial element, registered.
REQ-010 out_valid  output  1  out_data holds a valid element.
REQ-011 out_ready  input  1  downstream accepts element.
REQ-012 out_last  output  1  high with out_valid on element BLOCK_WIDTH-1 of a word.

Function
REQ-013 A word SHALL transfer in when in_valid && in_ready at a rising edge; an element SHALL transfer out when out_valid && out_ready at a rising edge.
REQ-014 Elements SHALL be emitted in ascending index order: element 0 first, element BLOCK_WIDTH-1 last.
REQ-015 The state machine SHALL have two states: EMPTY (out_valid=0) and SEND (out_valid=1).
REQ-016 EMPTY -> SEND on a word transfer-in; the element index resets to 0 and element 0 is presented on the following cycle (latency 1).
REQ-017 In SEND, each transfer-out SHALL increment the element index by 1; out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-018 SEND -> EMPTY on transfer-out of element BLOCK_WIDTH-1 unless a next word is available per REQ-024.
REQ-019 The element index counter SHALL be clog2(BLOCK_WIDTH) bits and SHALL never exceed BLOCK_WIDTH-1 (no wrap to unused codes).
REQ-020 in_ready SHALL be a registered signal, independent of in_valid in the same cycle (no combinational input-to-output path).
REQ-021 in_valid while in_ready=0 SHALL be ignored; in_data SHALL only be sampled on transfer-in.
REQ-022 out_last SHALL be 0 whenever out_valid=0.

Reset
REQ-023 While rst=0: state EMPTY, index 0, out_valid=0, out_last=0, out_data=0, in_ready=0; in_ready SHALL rise to 1 on the first rising edge after rst deasserts; assertion mid-word SHALL discard the partial word and any buffered word.

Configuration
REQ-024 Macro KERNEL_SERIALIZER_PREFETCH_EN SHALL, when defined, add one holding register: in_ready=1 whenever the holding register is empty, so a word is accepted during SEND; on transfer-out of element BLOCK_WIDTH-1 with the holder full, element 0 of the held word SHALL appear the next cycle (sustained 1 element/cycle, no bubble).
REQ-025 Without KERNEL_SERIALIZER_PREFETCH_EN, in_ready SHALL be 1 only in EMPTY, giving one idle cycle between consecutive words (BLOCK_WIDTH+1 cycles per word with out_ready=1).

Verification
REQ-026 Defaults, in_data=24'hCCBBAA pulsed 1 cycle, out_ready=1 -> out_data AA,BB,CC on 3 consecutive cycles starting 1 cycle after accept; out_last only with CC.
REQ-027 Same word, out_ready=0 for 4 cycles after first element -> out_data stays AA, out_valid=1, then BB,CC once out_ready=1.
REQ-028 in_valid held 1 with words 24'h030201, 24'h060504, out_ready=1 -> 01..06 in order; with PREFETCH_EN no out_valid gap, without it exactly one gap cycle between 03 and 04.
REQ-029 rst pulsed low after element BB of 24'hCCBBAA -> out_valid=0 immediately, CC never emitted, next word 24'h112233 emits 33,22,11.
REQ-030 in_valid=1 with in_data changing every cycle while in_ready=0 -> only sampled words appear at the output; no element duplicated or dropped.

Source files
------------

// File: rtl/kernel_serializer.sv
// Parallel-to-serial converter: one BLOCK_WIDTH-element word in, elements out lowest index first.
// Define KERNEL_SERIALIZER_PREFETCH_EN to add a one-word holding register for gap-free streaming.
module kernel_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_WIDTH = 3,
  parameter int INPUT_WIDTH = DATA_WIDTH * BLOCK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);
  localparam int IDX_W = (BLOCK_WIDTH > 1) ? $clog2(BLOCK_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WIDTH - 1);

  typedef enum logic {EMPTY, SEND} state_t;
  typedef logic [BLOCK_WIDTH-1:0][DATA_WIDTH-1:0] word_t;

  state_t                state_q, state_d;
  word_t                 word_q, word_d, in_word, load_word;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  last_d, rdy_d, load;
  logic                  accept, xfer_out, xfer_last;
`ifdef KERNEL_SERIALIZER_PREFETCH_EN
  word_t                 hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
`endif

  assign in_word   = in_data;
  assign out_valid = (state_q == SEND);
  assign accept    = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;
  assign xfer_last = xfer_out && (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    data_d    = out_data;
    last_d    = out_last;
    load      = 1'b0;
    load_word = in_word;
`ifdef KERNEL_SERIALIZER_PREFETCH_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif
    case (state_q)
      EMPTY: if (accept) load = 1'b1;
      SEND: begin
        if (xfer_last) begin
`ifdef KERNEL_SERIALIZER_PREFETCH_EN
          // Held word wins; an accept here implies the holder was empty, so bypass it.
          if (hold_vld_q) begin
            load       = 1'b1;
            load_word  = hold_q;
            hold_vld_d = 1'b0;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
`else
          state_d = EMPTY;
`endif
        end else begin
          if (xfer_out) begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = word_q[idx_d];
            last_d = (idx_d == LAST_IDX);
          end
`ifdef KERNEL_SERIALIZER_PREFETCH_EN
          if (accept) begin
            hold_d     = in_word;
            hold_vld_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = EMPTY;
    endcase

    if (load) begin
      state_d = SEND;
      word_d  = load_word;
      idx_d   = '0;
      data_d  = load_word[0];
      last_d  = 1'b0;
    end
    if (state_d == EMPTY) last_d = 1'b0;

`ifdef KERNEL_SERIALIZER_PREFETCH_EN
    rdy_d = !hold_vld_d;
`else
    rdy_d = (state_d == EMPTY);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      word_q   <= '0;
      idx_q    <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      out_data <= data_d;
      out_last <= last_d;
      in_ready <= rdy_d;
    end
  end

`ifdef KERNEL_SERIALIZER_PREFETCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_serializer.sv
// Directed bench for kernel_serializer at default parameters (3 x 8-bit elements).
module tb_kernel_serializer;
  logic        clk, rst;
  logic [23:0] in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last;

  int n_chk = 0;
  int n_bad = 0;

`ifdef KERNEL_SERIALIZER_PREFETCH_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  kernel_serializer dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] words [2];
  logic [8:0]  exp_q [$];
  logic [8:0]  e;
  logic        acc, xfer;
  int          k, gaps, wi, nacc;

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    chk("rdy_after_rst", in_ready, 1);

    // Single word, free-flowing output
    in_data = 24'hCCBBAA; in_valid = 1'b1; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    chk("w1_v0", out_valid, 1); chk("w1_d0", out_data, 8'hAA); chk("w1_l0", out_last, 0);
    tick(); chk("w1_d1", out_data, 8'hBB); chk("w1_l1", out_last, 0);
    tick(); chk("w1_d2", out_data, 8'hCC); chk("w1_l2", out_last, 1);
    tick(); chk("w1_done_v", out_valid, 0); chk("w1_done_l", out_last, 0);
    chk("w1_rdy", in_ready, 1);

    // Backpressure holds the first element
    in_data = 24'hCCBBAA; in_valid = 1'b1; out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    chk("bp_d0", out_data, 8'hAA);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_v", out_valid, 1); chk("bp_hold_d", out_data, 8'hAA); chk("bp_hold_l", out_last, 0);
    end
    out_ready = 1'b1;
    tick(); chk("bp_d1", out_data, 8'hBB);
    tick(); chk("bp_d2", out_data, 8'hCC); chk("bp_l2", out_last, 1);
    tick(); chk("bp_done", out_valid, 0);

    // Back-to-back words with in_valid held high
    words[0] = 24'h030201; words[1] = 24'h060504;
    wi = 0; k = 0; gaps = 0;
    in_valid = 1'b1; in_data = words[0]; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        wi++;
        if (wi < 2) in_data = words[wi]; else in_valid = 1'b0;
      end
      if (out_valid) begin
        chk("b2b_seq", out_data, k + 1);
        k++;
      end else if (k > 0 && k < 6) begin
        gaps++;
      end
    end
    chk("b2b_cnt", k, 6);
    chk("b2b_gap", gaps, EXP_GAP);
    chk("b2b_idle", out_valid, 0);

    // Reset in the middle of a word
    in_data = 24'hCCBBAA; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("mr_d0", out_data, 8'hAA);
    tick(); chk("mr_d1", out_data, 8'hBB);
    rst = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0); chk("mr_last", out_last, 0);
    chk("mr_data", out_data, 0); chk("mr_rdy", in_ready, 0);
    tick(); rst = 1'b1;
    tick(); chk("mr_rdy_up", in_ready, 1);
    in_data = 24'h112233; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("mr_n0", out_data, 8'h33);
    tick(); chk("mr_n1", out_data, 8'h22);
    tick(); chk("mr_n2", out_data, 8'h11); chk("mr_n2_l", out_last, 1);
    tick(); chk("mr_end", out_valid, 0);

    // in_data churns every cycle; only accepted words may appear, element for element
    nacc = 0;
    for (int c = 0; c < 80; c++) begin
      in_data   = {8'(8'h40 + c * 3 + 2), 8'(8'h40 + c * 3 + 1), 8'(8'h40 + c * 3)};
      in_valid  = (c < 24);
      out_ready = (c % 4 != 3);
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (acc) begin
        nacc++;
        exp_q.push_back({1'b0, in_data[7:0]});
        exp_q.push_back({1'b0, in_data[15:8]});
        exp_q.push_back({1'b1, in_data[23:16]});
      end
      if (xfer) begin
        chk("ch_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ch_data", out_data, e[7:0]);
          chk("ch_last", out_last, e[8]);
        end
      end
      if (c >= 24 && exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("ch_drain", exp_q.size(), 0);
    chk("ch_some_acc", nacc > 2, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
